// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix frame-buffer controller: buffer
// geometry, word widths, FSM state encoding and the default clear pixel.
package matrix_pkg;

    localparam int DEPTH   = 1024;        // words per buffer
    localparam int ADDR_W  = 10;          // word address within one buffer
    localparam int WADDR_W = ADDR_W + 1;  // {buffer, word address}
    localparam int PIX_W   = 12;          // {r[3:0], g[3:0], b[3:0]}

    localparam logic [PIX_W-1:0] CLR_DATA_DEFAULT = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SWAP  = 2'd2
    } fb_state_t;

endpackage

// File: rtl/matrix_clear_gen.sv
// Clear address generator: walks word addresses 0..DEPTH-1 and marks
// the final word so the controller knows which beat ends the clear.
module matrix_clear_gen
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // Restart at word 0 on start, step once per issued clear beat.
    // Stepping past the last word wraps back to 0 for the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (start) begin
            addr <= '0;
        end else if (advance) begin
            addr <= addr + 1'b1;
        end
    end

    assign last = (addr == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/matrix_fb_ctrl.sv
// Double-buffered LED-matrix frame-buffer controller. Host writes and
// clear beats always land in the back buffer; a swap flips which buffer
// the panel driver shows and waits until the driver has followed.
//
// Host handshake: h_req is the valid, h_rdy the ready. A beat
// (h_addr/h_data) is accepted in exactly the cycles where h_req && h_rdy
// at the rising clock edge; h_rdy never depends on h_req.
module matrix_fb_ctrl
    import matrix_pkg::*;
#(
    parameter bit               CLR_ON_SWAP = 1'b0,
    parameter logic [PIX_W-1:0] CLR_DATA    = CLR_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h_req,
    input  logic [ADDR_W-1:0]  h_addr,
    input  logic [PIX_W-1:0]   h_data,
    output logic               h_rdy,
    input  logic               clr_start,
    input  logic               swap_req,
    output logic               clr_done,
    output logic               swap_done,
    output logic               busy,
    output logic               wr,
    output logic [WADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    output logic               buffer_select,
    input  logic               buffer_current,
    output fb_state_t          state_dbg
);

    fb_state_t         state, next_state;
    logic              clr_pend, swap_pend;
    logic              rr_clear;      // 1: clear owns the next CLEAR slot
    logic              host_beat, clr_beat;
    logic              clr_entry, swap_entry, swap_exit;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;

    matrix_clear_gen u_clear_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (clr_entry),
        .advance (clr_beat),
        .addr    (clr_addr),
        .last    (clr_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, host ready and beat selection for the current cycle.
    always_comb begin
        next_state = state;
        h_rdy      = 1'b0;
        host_beat  = 1'b0;
        clr_beat   = 1'b0;
        clr_entry  = 1'b0;
        swap_entry = 1'b0;
        swap_exit  = 1'b0;
        case (state)
            ST_IDLE: begin
                h_rdy     = 1'b1;
                host_beat = h_req;
                if (clr_pend) begin
                    next_state = ST_CLEAR;
                    clr_entry  = 1'b1;
                end else if (swap_pend) begin
                    next_state = ST_SWAP;
                    swap_entry = 1'b1;
                end
            end
            ST_CLEAR: begin
                h_rdy     = ~rr_clear;
                host_beat = h_req & ~rr_clear;
                clr_beat  = ~host_beat;
                if (clr_beat && clr_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SWAP: begin
                if (buffer_current == buffer_select) begin
                    swap_exit = 1'b1;
                    if (CLR_ON_SWAP) begin
                        next_state = ST_CLEAR;
                        clr_entry  = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sticky request flags: a new pulse wins over the service that clears them,
    // so a request arriving during its own operation causes one more run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_pend  <= 1'b0;
            swap_pend <= 1'b0;
        end else begin
            clr_pend  <= (clr_pend  & ~clr_entry)  | clr_start;
            swap_pend <= (swap_pend & ~swap_entry) | swap_req;
        end
    end

    // Round-robin pointer: host gets the first CLEAR slot, then slots alternate
    // while the host keeps requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_clear <= 1'b0;
        end else if (clr_entry) begin
            rr_clear <= 1'b0;
        end else if (state == ST_CLEAR) begin
            rr_clear <= host_beat;
        end
    end

    // Displayed-buffer request flips as the SWAP state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_select <= 1'b0;
        end else if (swap_entry) begin
            buffer_select <= ~buffer_select;
        end
    end

    // Registered write port and completion pulses; one cycle after the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr        <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            clr_done  <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            wr        <= host_beat | clr_beat;
            clr_done  <= clr_beat & clr_last;
            swap_done <= swap_exit;
            if (host_beat) begin
                wr_addr <= {~buffer_select, h_addr};
                wr_data <= h_data;
            end else if (clr_beat) begin
                wr_addr <= {~buffer_select, clr_addr};
                wr_data <= CLR_DATA;
            end
        end
    end

    assign busy      = (state != ST_IDLE) | clr_pend | swap_pend;
    assign state_dbg = state;

endmodule

// File: tb/tb_matrix_fb_ctrl.sv
// Directed bench for matrix_fb_ctrl: single write, idle clear, clear with
// host contention, held swap, combined clear+swap and reset mid-clear.
module tb_matrix_fb_ctrl;
    import matrix_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               h_req;
    logic [ADDR_W-1:0]  h_addr;
    logic [PIX_W-1:0]   h_data;
    logic               h_rdy;
    logic               clr_start;
    logic               swap_req;
    logic               clr_done;
    logic               swap_done;
    logic               busy;
    logic               wr;
    logic [WADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]   wr_data;
    logic               buffer_select;
    logic               buffer_current;
    fb_state_t          state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WADDR_W+PIX_W-1:0] exp_q[$];
    logic [WADDR_W+PIX_W-1:0] exp_beat;

    matrix_fb_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .h_req          (h_req),
        .h_addr         (h_addr),
        .h_data         (h_data),
        .h_rdy          (h_rdy),
        .clr_start      (clr_start),
        .swap_req       (swap_req),
        .clr_done       (clr_done),
        .swap_done      (swap_done),
        .busy           (busy),
        .wr             (wr),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .buffer_select  (buffer_select),
        .buffer_current (buffer_current),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until a write beat shows up, bounded.
    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (!wr && n < 20) begin
            tick();
            n++;
        end
        check(tag, wr, 1);
    endtask

    initial begin
        int k, clr_idx, host_seen, clr_cycles, cyc;
        bit done;

        rst = 1'b1; h_req = 1'b0; h_addr = '0; h_data = '0;
        clr_start = 1'b0; swap_req = 1'b0; buffer_current = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_wr", wr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_sel", buffer_select, 0);
        check("rst_busy", busy, 0);
        check("rst_clr_done", clr_done, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        tick();
        check("post_rst_wr", wr, 0);

        // Single host write goes to back buffer 1
        h_req = 1'b1; h_addr = 10'h2A5; h_data = 12'hF0F;
        #1;
        check("idle_h_rdy", h_rdy, 1);
        tick();
        h_req = 1'b0;
        check("host_wr", wr, 1);
        check("host_wr_addr", wr_addr, 11'h6A5);
        check("host_wr_data", wr_data, 12'hF0F);
        tick();
        check("host_wr_single", wr, 0);

        // Clear with host idle: 1024 back-to-back beats into buffer 1
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_busy", busy, 1);
        wait_wr("clr_first_beat");
        for (int i = 0; i < 1024; i++) begin
            check("clr_wr", wr, 1);
            check("clr_addr", wr_addr, 32'h400 + i);
            check("clr_data", wr_data, 12'h000);
            check("clr_done_pulse", clr_done, (i == 1023));
            tick();
        end
        check("clr_end_wr", wr, 0);
        check("clr_end_done", clr_done, 0);
        check("clr_end_busy", busy, 0);

        // Clear with host requesting every cycle: alternate, host first
        clr_start = 1'b1; h_req = 1'b1;
        k = 0; clr_idx = 0; host_seen = 0; clr_cycles = 0; cyc = 0; done = 1'b0;
        h_addr = 10'(k * 37); h_data = 12'h800 | 12'(k);
        while (!done && cyc < 2300) begin
            #1;
            if (h_req && h_rdy) begin
                exp_q.push_back({1'b1, h_addr, h_data});
                k++;
            end
            if (state_dbg == ST_CLEAR) clr_cycles++;
            tick();
            cyc++;
            clr_start = 1'b0;
            if (wr) begin
                if (wr_data == 12'h000) begin
                    check("rr_clr_addr", wr_addr, 32'h400 + clr_idx);
                    clr_idx++;
                    check("rr_clr_done", clr_done, (clr_idx == 1024));
                    if (clr_done) done = 1'b1;
                end else begin
                    host_seen++;
                    check("rr_host_queue", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_beat = exp_q.pop_front();
                        check("rr_host_beat", {wr_addr, wr_data}, exp_beat);
                    end
                end
            end
            h_addr = 10'(k * 37); h_data = 12'h800 | 12'(k);
            if (done) h_req = 1'b0;
        end
        h_req = 1'b0;
        check("rr_done_seen", done, 1);
        check("rr_clear_beats", clr_idx, 1024);
        check("rr_clear_cycles", clr_cycles, 2048);
        check("rr_host_beats", host_seen, 1026);
        check("rr_host_lost", exp_q.size(), 0);

        // Swap held off by the panel driver for 200 cycles
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("swap_busy", busy, 1);
        check("swap_sel_before", buffer_select, 0);
        tick();
        check("swap_sel_toggled", buffer_select, 1);
        check("swap_state", state_dbg, ST_SWAP);
        h_req = 1'b1; h_addr = 10'h155; h_data = 12'h555;
        for (int i = 0; i < 200; i++) begin
            check("swap_h_rdy", h_rdy, 0);
            check("swap_no_wr", wr, 0);
            check("swap_done_early", swap_done, 0);
            tick();
        end
        h_req = 1'b0;
        buffer_current = 1'b1;
        tick();
        check("swap_done_pulse", swap_done, 1);
        check("swap_busy_end", busy, 0);
        tick();
        check("swap_done_single", swap_done, 0);
        check("swap_sel_kept", buffer_select, 1);
        h_req = 1'b1; h_addr = 10'h123; h_data = 12'hABC;
        tick();
        h_req = 1'b0;
        check("post_swap_wr", wr, 1);
        check("post_swap_addr", wr_addr, 11'h123);
        check("post_swap_data", wr_data, 12'hABC);

        // Clear and swap requested together: clear of buffer 0 first, then swap
        clr_start = 1'b1; swap_req = 1'b1;
        tick();
        clr_start = 1'b0; swap_req = 1'b0;
        wait_wr("both_first_beat");
        for (int i = 0; i < 1024; i++) begin
            check("both_clr_addr", wr_addr, i);
            check("both_clr_wr", wr, 1);
            check("both_clr_done", clr_done, (i == 1023));
            check("both_sel_hold", buffer_select, 1);
            tick();
        end
        check("both_sel_toggled", buffer_select, 0);
        check("both_state_swap", state_dbg, ST_SWAP);
        check("both_busy", busy, 1);
        check("both_swap_done_early", swap_done, 0);
        buffer_current = 1'b0;
        tick();
        check("both_swap_done", swap_done, 1);
        tick();
        check("both_swap_single", swap_done, 0);
        check("both_idle", busy, 0);

        // Reset in the middle of a clear, at beat 500
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_wr("rstmid_first_beat");
        for (int i = 0; i < 500; i++) tick();
        check("rstmid_beat500_addr", wr_addr, 32'h400 + 500);
        check("rstmid_beat500_wr", wr, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_wr", wr, 0);
        check("rstmid_wr_addr", wr_addr, 0);
        check("rstmid_wr_data", wr_data, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_sel", buffer_select, 0);
        check("rstmid_clr_done", clr_done, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_first_cycle_wr", wr, 0);
        check("rstmid_busy_after", busy, 0);
        check("rstmid_state", state_dbg, ST_IDLE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstmid_no_wr", wr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_fb_ctrl.md
MATRIX_FB_CTRL -- requirements
Module: matrix_fb_ctrl

Interface
REQ-001 Parameter: CLR_ON_SWAP, 0, when 1 an automatic back-buffer clear starts after every completed swap.
REQ-002 Parameter: CLR_DATA, 12'h000, pixel word written by every clear operation.
REQ-003 clk  in  1  single clock for all logic, shared with the panel driver and its memory write port; one clock, reset is asynchronous and active-high.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 h_req  in  1  host write request; h_addr/h_data valid while high.
REQ-006 h_addr  in  10  word address within the back buffer: bit 9 selects rows 16-31 memory, bits 8:0 = {row[3:0], col[4:0]}.
REQ-007 h_data  in  12  {r[3:0], g[3:0], b[3:0]} pixel word.
REQ-008 h_rdy  out  1  host write accepted in any cycle where h_req && h_rdy.
REQ-009 clr_start  in  1  one-cycle pulse requesting a back-buffer clear.
REQ-010 swap_req  in  1  one-cycle pulse requesting front/back buffer exchange.
REQ-011 clr_done, swap_done  out  1 each  one-cycle completion pulses.
REQ-012 busy  out  1  high whenever state is not IDLE or a request is pending.
REQ-013 wr, wr_addr[10:0], wr_data[11:0]  out  registered write port to the panel driver memory.
REQ-014 buffer_select  out  1  buffer the panel driver shall display from its next frame.
REQ-015 buffer_current  in  1  buffer the panel driver is displaying now.

Function
REQ-016 States: IDLE, CLEAR, SWAP; clr_start/swap_req set sticky pending flags clr_pend/swap_pend, cleared on service.
REQ-017 IDLE: clr_pend has priority over swap_pend; clr_pend -> CLEAR, else swap_pend -> SWAP.
REQ-018 All writes target the back buffer: wr_addr = {~buffer_select, addr[9:0]}.
REQ-019 Write latency: accepted host beat or clear beat appears on wr/wr_addr/wr_data exactly one cycle later; wr high for exactly one cycle per beat.
REQ-020 IDLE: h_rdy = 1 combinationally; every host beat accepted.
REQ-021 CLEAR: 10-bit counter 0..1023 issues CLR_DATA beats; when h_req also high, round-robin alternation host/clear per cycle, host first after entry.
REQ-022 CLEAR end: beat 1023 issued -> clr_done pulses in the cycle its wr is asserted, counter returns to 0, -> IDLE.
REQ-023 SWAP: h_rdy = 0 and no writes; buffer_select toggles on the entry cycle; remain until buffer_current == buffer_select, then swap_done pulse and -> CLEAR if CLR_ON_SWAP else IDLE.
REQ-024 clr_start during CLEAR is latched and produces a second full clear; swap_req during SWAP is latched and produces a second swap.
REQ-025 clr_start and swap_req in the same cycle: clear completes first, then swap.
REQ-026 busy = (state != IDLE) | clr_pend | swap_pend.

Reset
REQ-027 On rst: state IDLE, pending flags 0, counter 0, round-robin pointer = host, buffer_select 0, wr 0, wr_addr 0, wr_data 0, clr_done 0, swap_done 0.
REQ-028 Reset mid-clear or mid-swap abandons the operation; no wr pulse in the first cycle after rst deasserts.

Structure
REQ-029 Shared package matrix_pkg holds state encoding, buffer depth (1024), address/pixel widths and CLR_DATA default.
REQ-030 Single sub-module matrix_clear_gen: clear address counter with start/advance/last outputs.

Verification
REQ-031 buffer_current=0, host writes addr 10'h2A5 data 12'hF0F -> next cycle wr=1, wr_addr=11'h6A5, wr_data=12'hF0F.
REQ-032 clr_start, host idle -> 1024 consecutive wr beats addrs {1,0..1023}, data 12'h000, clr_done with beat 1023.
REQ-033 clr_start, h_req held high -> alternating host/clear beats, clear takes 2048 cycles, no host beat lost.
REQ-034 swap_req, model holds buffer_current for 200 cycles -> buffer_select=1 next cycle, h_rdy=0 for 200 cycles, swap_done single pulse, later writes target buffer 0.
REQ-035 clr_start and swap_req same cycle -> full clear, clr_done, then buffer_select toggle, swap_done.
REQ-036 rst asserted at clear beat 500 -> all outputs reset values, no further wr, busy=0 after release.
